// File: rtl/frame_reader_if.sv
// Pixel-consumer and frame-buffer read-port signals of the frame reader.
// The slave modport is the frame reader's view; master is the surrounding system.
interface frame_reader_if;
   logic        frame_start;
   logic        pix_rd;
   logic        pix_valid;
   logic [7:0]  color;
   logic [7:0]  VGA_R;
   logic [7:0]  VGA_G;
   logic [7:0]  VGA_B;
   logic        rd_en;
   logic [18:0] rd_addr;
   logic [7:0]  rd_data;
   logic        underflow;

   modport master (
      output frame_start, pix_rd, rd_data,
      input  pix_valid, color, VGA_R, VGA_G, VGA_B, rd_en, rd_addr, underflow
   );

   modport slave (
      input  frame_start, pix_rd, rd_data,
      output pix_valid, color, VGA_R, VGA_G, VGA_B, rd_en, rd_addr, underflow
   );
endinterface

// File: rtl/frame_reader.sv
// Frame-buffer scan-out: sequential RGB332 fetch into a show-ahead FIFO, expanded to 8:8:8 VGA colour.
// A pixel is visible RD_LAT+1 cycles after its read; fetching stalls while FIFO plus in-flight reads fill FIFO_DEPTH.
module frame_reader #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int FIFO_DEPTH = 16,
   parameter int RD_LAT     = 2
) (
   input logic           clk,
   input logic           r,
   frame_reader_if.slave bus
);
   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam int          CW        = AW + 1;
   localparam logic [18:0] LAST_ADDR = 19'(H_RES * V_RES - 1);

   typedef enum logic {ST_FETCH, ST_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [18:0]       r_addr;
   logic [RD_LAT-1:0] r_vld;
   logic [RD_LAT:0]   w_vld_shift;
   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     w_inflight;
   logic [CW:0]       w_occupancy;
   logic              r_underflow;
   logic              w_credit_ok;
   logic              w_rd_en;
   logic              w_push;
   logic              w_pop;
   logic              w_pix_valid;
   logic [7:0]        w_color;

   // Credit: every issued read owns a FIFO slot until it is popped, so a push never meets a full FIFO.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         w_inflight = w_inflight + CW'(r_vld[i]);
      end
   end

   assign w_occupancy = {1'b0, r_count} + {1'b0, w_inflight};
   assign w_credit_ok = (w_occupancy < (CW+1)'(FIFO_DEPTH));

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.frame_start) begin
         w_state_nxt = ST_FETCH;
      end else if ((r_state == ST_FETCH) && w_rd_en && (r_addr == LAST_ADDR)) begin
         w_state_nxt = ST_DONE;
      end
   end

   // Gated by the reset input so the read port is quiet while reset is held.
   always_comb begin
      w_rd_en = 1'b0;
      if (r && (r_state == ST_FETCH) && !bus.frame_start && w_credit_ok) begin
         w_rd_en = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         r_addr <= '0;
      end else if (bus.frame_start) begin
         r_addr <= '0;
      end else if (w_rd_en && (r_addr != LAST_ADDR)) begin
         r_addr <= r_addr + 19'd1;
      end
   end

   // Top bit of the shift vector is the read whose data is on rd_data this cycle.
   assign w_vld_shift = {r_vld, w_rd_en};
   assign w_push      = w_vld_shift[RD_LAT] && !bus.frame_start;
   assign w_pix_valid = (r_count != '0);
   assign w_pop       = bus.pix_rd && w_pix_valid && !bus.frame_start;

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         r_vld <= '0;
      end else if (bus.frame_start) begin
         r_vld <= '0;
      end else begin
         r_vld <= w_vld_shift[RD_LAT-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= bus.rd_data;
      end
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (bus.frame_start) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         r_underflow <= 1'b0;
      end else if (bus.frame_start) begin
         r_underflow <= 1'b0;
      end else if (bus.pix_rd && !w_pix_valid) begin
         r_underflow <= 1'b1;
      end
   end

   assign w_color = w_pix_valid ? r_mem[r_rptr] : 8'h00;

   assign bus.pix_valid = w_pix_valid;
   assign bus.color     = w_color;
   assign bus.VGA_R     = {w_color[7:5], w_color[7:5], w_color[7:6]};
   assign bus.VGA_G     = {w_color[4:2], w_color[4:2], w_color[4:3]};
   assign bus.VGA_B     = {4{w_color[1:0]}};
   assign bus.rd_en     = w_rd_en;
   assign bus.rd_addr   = r_addr;
   assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader on a reduced 64x20 frame with a latency-2 frame-buffer model returning addr[7:0].
module tb_frame_reader;
   localparam int H     = 64;
   localparam int V     = 20;
   localparam int DEPTH = 16;
   localparam int LAT   = 2;
   localparam int NPIX  = H * V;

   logic clk = 1'b0;
   logic r;
   frame_reader_if bus();

   always #5 clk = ~clk;

   frame_reader #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(DEPTH), .RD_LAT(LAT)) dut (
      .clk (clk),
      .r   (r),
      .bus (bus)
   );

   logic [7:0] mem_p0, mem_p1;
   always @(posedge clk) begin
      mem_p0 <= bus.rd_en ? bus.rd_addr[7:0] : 8'h5A;
      mem_p1 <= mem_p0;
   end
   assign bus.rd_data = mem_p1;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_pop;

   typedef struct {int due; logic [7:0] pix;} ent_t;

   function automatic logic [7:0] exp_vr(input logic [7:0] c); return {c[7:5], c[7:5], c[7:6]}; endfunction
   function automatic logic [7:0] exp_vg(input logic [7:0] c); return {c[4:2], c[4:2], c[4:3]}; endfunction
   function automatic logic [7:0] exp_vb(input logic [7:0] c); return {c[1:0], c[1:0], c[1:0], c[1:0]}; endfunction

   task automatic drive(input logic fs, input logic rd);
      bus.frame_start = fs;
      bus.pix_rd      = rd;
      @(negedge clk);
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      r = 1'b0;
      bus.frame_start = 1'b0;
      bus.pix_rd = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", bus.rd_en); end
      n_checks++; if (bus.rd_addr !== 19'd0) begin n_fail++; $display("FAIL reset_rd_addr got %0d want 0", bus.rd_addr); end
      n_checks++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid got %b want 0", bus.pix_valid); end
      n_checks++; if (bus.color !== 8'h00) begin n_fail++; $display("FAIL reset_color got %h want 00", bus.color); end
      n_checks++; if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'h0) begin n_fail++; $display("FAIL reset_vga got %h want 0", {bus.VGA_R, bus.VGA_G, bus.VGA_B}); end
      n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got %b want 0", bus.underflow); end
   endtask

   task automatic test_fill();
      next_edge();
      r = 1'b1;
      for (int k = 0; k < 30; k++) begin
         drive(1'b0, 1'b0);
         n_checks++; if (bus.rd_en !== (k < DEPTH)) begin n_fail++; $display("FAIL fill_rd_en cyc %0d got %b want %b", k, bus.rd_en, (k < DEPTH)); end
         if (k < DEPTH) begin
            n_checks++; if (bus.rd_addr !== 19'(k)) begin n_fail++; $display("FAIL fill_rd_addr cyc %0d got %0d want %0d", k, bus.rd_addr, k); end
         end
         n_checks++; if (bus.pix_valid !== (k >= 3)) begin n_fail++; $display("FAIL fill_pix_valid cyc %0d got %b want %b", k, bus.pix_valid, (k >= 3)); end
         if (k == 3) begin
            n_checks++; if (bus.color !== 8'h00) begin n_fail++; $display("FAIL fill_head_color got %h want 00", bus.color); end
         end
         next_edge();
      end
   endtask

   task automatic test_stream();
      exp_pop = 0;
      repeat (1000) begin
         drive(1'b0, 1'b1);
         n_checks++; if (bus.pix_valid !== 1'b1) begin n_fail++; $display("FAIL stream_pix_valid pop %0d got %b want 1", exp_pop, bus.pix_valid); end
         n_checks++; if (bus.color !== exp_pop[7:0]) begin n_fail++; $display("FAIL stream_color pop %0d got %h want %h", exp_pop, bus.color, exp_pop[7:0]); end
         n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL stream_underflow got %b want 0", bus.underflow); end
         if (bus.pix_valid) exp_pop++;
         next_edge();
      end
   endtask

   task automatic test_full_frame();
      int cyc = 0;
      logic [7:0] last_color = 8'h00;
      while (exp_pop < NPIX && cyc < 1000) begin
         drive(1'b0, 1'b1);
         if (bus.rd_en) begin
            n_checks++; if (bus.rd_addr > 19'(NPIX - 1)) begin n_fail++; $display("FAIL frame_addr_range got %0d want <= %0d", bus.rd_addr, NPIX - 1); end
         end
         if (bus.pix_valid) begin
            n_checks++; if (bus.color !== exp_pop[7:0]) begin n_fail++; $display("FAIL frame_color pop %0d got %h want %h", exp_pop, bus.color, exp_pop[7:0]); end
            last_color = bus.color;
            exp_pop++;
         end
         next_edge();
         cyc++;
      end
      n_checks++; if (exp_pop != NPIX) begin n_fail++; $display("FAIL frame_pop_count got %0d want %0d", exp_pop, NPIX); end
      n_checks++; if (last_color !== 8'hFF) begin n_fail++; $display("FAIL frame_last_color got %h want ff", last_color); end
      repeat (20) begin
         drive(1'b0, 1'b0);
         n_checks++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL done_pix_valid got %b want 0", bus.pix_valid); end
         n_checks++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL done_rd_en got %b want 0", bus.rd_en); end
         n_checks++; if (bus.rd_addr !== 19'(NPIX - 1)) begin n_fail++; $display("FAIL done_rd_addr got %0d want %0d", bus.rd_addr, NPIX - 1); end
         next_edge();
      end
   endtask

   task automatic test_frame_start();
      int cyc = 0;
      drive(1'b1, 1'b0);
      n_checks++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL fs_rd_en got %b want 0", bus.rd_en); end
      next_edge();
      exp_pop = 0;
      while (bus.rd_addr != 19'd502 && cyc < 2000) begin
         drive(1'b0, 1'b1);
         if (bus.pix_valid) begin
            n_checks++; if (bus.color !== exp_pop[7:0]) begin n_fail++; $display("FAIL fs_pre_color pop %0d got %h want %h", exp_pop, bus.color, exp_pop[7:0]); end
            exp_pop++;
         end
         next_edge();
         cyc++;
      end
      n_checks++; if (cyc >= 2000) begin n_fail++; $display("FAIL fs_reach_502 timeout rd_addr %0d want 502", bus.rd_addr); end
      drive(1'b1, 1'b1);
      n_checks++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL fs_mid_rd_en got %b want 0", bus.rd_en); end
      next_edge();
      drive(1'b0, 1'b0);
      n_checks++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL fs_after_pix_valid got %b want 0", bus.pix_valid); end
      n_checks++; if (bus.rd_en !== 1'b1) begin n_fail++; $display("FAIL fs_after_rd_en got %b want 1", bus.rd_en); end
      n_checks++; if (bus.rd_addr !== 19'd0) begin n_fail++; $display("FAIL fs_after_rd_addr got %0d want 0", bus.rd_addr); end
      next_edge();
      exp_pop = 0;
      repeat (40) begin
         drive(1'b0, 1'b1);
         if (bus.pix_valid) begin
            n_checks++; if (bus.color !== exp_pop[7:0]) begin n_fail++; $display("FAIL fs_new_color pop %0d got %h want %h", exp_pop, bus.color, exp_pop[7:0]); end
            exp_pop++;
         end
         next_edge();
      end
      n_checks++; if (exp_pop != 38) begin n_fail++; $display("FAIL fs_new_pop_count got %0d want 38", exp_pop); end
   endtask

   task automatic test_underflow();
      drive(1'b1, 1'b0);
      next_edge();
      drive(1'b0, 1'b1);
      n_checks++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL uf_empty_pix_valid got %b want 0", bus.pix_valid); end
      next_edge();
      exp_pop = 0;
      repeat (30) begin
         drive(1'b0, 1'b1);
         n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky got %b want 1", bus.underflow); end
         if (bus.pix_valid) begin
            n_checks++; if (bus.color !== exp_pop[7:0]) begin n_fail++; $display("FAIL uf_color pop %0d got %h want %h", exp_pop, bus.color, exp_pop[7:0]); end
            exp_pop++;
         end
         next_edge();
      end
      drive(1'b1, 1'b0);
      n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL uf_fs_cycle got %b want 1", bus.underflow); end
      next_edge();
      drive(1'b0, 1'b0);
      n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL uf_cleared got %b want 0", bus.underflow); end
      next_edge();
   endtask

   // Reference: each issued pixel is owed to the consumer and becomes visible 3 cycles after issue.
   task automatic test_random();
      ent_t q[$];
      int   exp_addr = 0;
      logic uf = 1'b0;
      int   now = 0;
      logic fs, rd, ev, er;
      logic [7:0] ec;
      for (int i = 0; i < 3000; i++) begin
         fs = (i == 0) || ($urandom_range(0, 399) == 0);
         rd = ($urandom_range(0, 9) < 7);
         drive(fs, rd);
         ev = (q.size() > 0) && (q[0].due <= now);
         er = !fs && (exp_addr < NPIX) && (q.size() < DEPTH);
         ec = ev ? q[0].pix : 8'h00;
         if (i > 0) begin
            n_checks++; if (bus.pix_valid !== ev) begin n_fail++; $display("FAIL rnd_pix_valid cyc %0d got %b want %b", i, bus.pix_valid, ev); end
            n_checks++; if (bus.rd_en !== er) begin n_fail++; $display("FAIL rnd_rd_en cyc %0d got %b want %b", i, bus.rd_en, er); end
            if (er) begin
               n_checks++; if (bus.rd_addr !== 19'(exp_addr)) begin n_fail++; $display("FAIL rnd_rd_addr cyc %0d got %0d want %0d", i, bus.rd_addr, exp_addr); end
            end
            n_checks++; if (bus.color !== ec) begin n_fail++; $display("FAIL rnd_color cyc %0d got %h want %h", i, bus.color, ec); end
            n_checks++; if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== {exp_vr(ec), exp_vg(ec), exp_vb(ec)}) begin
               n_fail++; $display("FAIL rnd_vga cyc %0d got %h want %h", i, {bus.VGA_R, bus.VGA_G, bus.VGA_B}, {exp_vr(ec), exp_vg(ec), exp_vb(ec)});
            end
            n_checks++; if (bus.underflow !== uf) begin n_fail++; $display("FAIL rnd_underflow cyc %0d got %b want %b", i, bus.underflow, uf); end
         end
         if (fs) begin
            q.delete();
            exp_addr = 0;
            uf = 1'b0;
         end else begin
            if (rd && ev) void'(q.pop_front());
            if (rd && !ev) uf = 1'b1;
            if (er) begin
               q.push_back('{due: now + 3, pix: exp_addr[7:0]});
               exp_addr++;
            end
         end
         now++;
         next_edge();
      end
   endtask

   task automatic test_color_and_async_reset();
      int pops = 0;
      int cyc = 0;
      drive(1'b1, 1'b0);
      next_edge();
      while (pops < 227 && cyc < 1000) begin
         drive(1'b0, 1'b1);
         if (bus.pix_valid) pops++;
         next_edge();
         cyc++;
      end
      n_checks++; if (pops != 227) begin n_fail++; $display("FAIL vga_pop_timeout got %0d want 227", pops); end
      repeat (3) begin
         drive(1'b0, 1'b0);
         next_edge();
      end
      drive(1'b0, 1'b0);
      n_checks++; if (bus.color !== 8'hE3) begin n_fail++; $display("FAIL vga_head got %h want e3", bus.color); end
      n_checks++; if (bus.VGA_R !== 8'hFF) begin n_fail++; $display("FAIL vga_r got %h want ff", bus.VGA_R); end
      n_checks++; if (bus.VGA_G !== 8'h00) begin n_fail++; $display("FAIL vga_g got %h want 00", bus.VGA_G); end
      n_checks++; if (bus.VGA_B !== 8'hFF) begin n_fail++; $display("FAIL vga_b got %h want ff", bus.VGA_B); end
      next_edge();
      bus.pix_rd = 1'b1;
      @(posedge clk);
      #3;
      r = 1'b0;
      #1;
      n_checks++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL arst_rd_en got %b want 0", bus.rd_en); end
      n_checks++; if (bus.rd_addr !== 19'd0) begin n_fail++; $display("FAIL arst_rd_addr got %0d want 0", bus.rd_addr); end
      n_checks++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL arst_pix_valid got %b want 0", bus.pix_valid); end
      n_checks++; if (bus.color !== 8'h00) begin n_fail++; $display("FAIL arst_color got %h want 00", bus.color); end
      n_checks++; if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'h0) begin n_fail++; $display("FAIL arst_vga got %h want 0", {bus.VGA_R, bus.VGA_G, bus.VGA_B}); end
      n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL arst_underflow got %b want 0", bus.underflow); end
      bus.pix_rd = 1'b0;
      next_edge();
      r = 1'b1;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fill();
      test_stream();
      test_full_frame();
      test_frame_start();
      test_underflow();
      test_random();
      test_color_and_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
